// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and helpers for the instruction-fetch front end.
//   - fetch_state_t : fetch sequencer states (IDLE, REQ, WAIT, SQUASH)
//   - RMASK_ALL / RMASK_NONE : I-cache read-mask encodings
//   - pc_advance()  : sequential PC increment
//   The {pc,inst} queue entry type depends on INST_WIDTH, so it is declared
//   inside fetch_unit where that parameter is visible.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    localparam logic [3:0] RMASK_ALL  = 4'hF;
    localparam logic [3:0] RMASK_NONE = 4'h0;

    function automatic logic [31:0] pc_advance(input logic [31:0] pc, input int step);
        return pc + 32'(step);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Flushable circular buffer of fetched {pc,inst} entries.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     flush           empty the queue on the next edge (wins over enq/deq)
//     enq, enq_data   write one entry at the tail
//     deq             pop the head (ignored when empty)
//     deq_data        head entry, combinational read of registered storage
//     count           occupied entries (0..DEPTH)
//     full, empty     occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       deq,
    output logic [WIDTH-1:0]           deq_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             enq_ok_s;
    logic             deq_ok_s;

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign count    = count_r;
    assign deq_data = mem_r[head_r];

    // A write into a full queue is only accepted when the head leaves the same cycle.
    assign enq_ok_s = enq & (~full | deq);
    assign deq_ok_s = deq & ~empty;

    // Entry storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (enq_ok_s && !flush && !rst) begin
            mem_r[tail_r] <= enq_data;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_ok_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (deq_ok_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({enq_ok_s, deq_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end: owns the PC, issues one read at a time to a
//   blocking I-cache and buffers {pc,inst} pairs in fetch_fifo for dispatch.
//   Redirects flush the queue and restart at redirect_pc; a response belonging
//   to a request issued before the redirect is squashed. Requests are only
//   issued when the queue has room for every outstanding response.
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     ufp_addr, ufp_rmask              I-cache request (rmask=F one cycle)
//     ufp_rdata, ufp_resp              I-cache response
//     redirect_valid, redirect_pc      flush and restart fetch
//     deq_ready, deq_valid,
//     deq_inst, deq_pc                 dispatch-side head of queue
//     iq_full, iq_count                queue occupancy
//     perf_fetch/perf_stall/perf_flush performance counters
//   Build option: define FETCH_PERF_EN to build the performance counters;
//   otherwise the perf_* ports are tied to zero.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h1eceb000,
    parameter int          IQ_DEPTH   = 64,
    parameter int          INST_WIDTH = 32,
    parameter int          PC_STEP    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [31:0]                 ufp_addr,
    output logic [3:0]                  ufp_rmask,
    input  logic [INST_WIDTH-1:0]       ufp_rdata,
    input  logic                        ufp_resp,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        deq_ready,
    output logic                        deq_valid,
    output logic [INST_WIDTH-1:0]       deq_inst,
    output logic [31:0]                 deq_pc,
    output logic                        iq_full,
    output logic [$clog2(IQ_DEPTH):0]   iq_count,
    output logic [31:0]                 perf_fetch,
    output logic [31:0]                 perf_stall,
    output logic [31:0]                 perf_flush
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]           pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    localparam int             ENTRY_W = $bits(fetch_entry_t);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(IQ_DEPTH);

    fetch_state_t     state_r;
    fetch_state_t     state_next_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_next_s;
    logic [3:0]       rmask_r;
    logic             enq_s;
    logic             flush_s;
    logic             empty_s;
    logic             full_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W:0]   count_ext_s;
    logic             credit_idle_s;
    logic             credit_wait_s;
    fetch_entry_t     enq_entry_s;
    fetch_entry_t     head_entry_s;

    // Credit: occupied entries plus the outstanding request must stay within
    // the queue. In WAIT the responding request is the one in flight, so a new
    // request needs room for both it and the next response.
    assign count_ext_s   = {1'b0, count_s};
    assign credit_idle_s = (count_ext_s < DEPTH_C);
    assign credit_wait_s = ((count_ext_s + (CNT_W + 1)'(1)) < DEPTH_C);

    assign enq_entry_s.pc   = pc_r;
    assign enq_entry_s.inst = ufp_rdata;

    fetch_fifo #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_s),
        .enq      (enq_s),
        .enq_data (enq_entry_s),
        .deq      (deq_ready),
        .deq_data (head_entry_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign deq_valid = ~empty_s;
    assign deq_pc    = head_entry_s.pc;
    assign deq_inst  = head_entry_s.inst;
    assign iq_full   = full_s;
    assign iq_count  = count_s;
    assign ufp_addr  = pc_r;
    assign ufp_rmask = rmask_r;

    // Next-state, next-PC, enqueue and flush decisions.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        enq_s        = 1'b0;
        flush_s      = 1'b0;
        if (redirect_valid) begin
            flush_s   = 1'b1;
            pc_next_s = redirect_pc;
            case (state_r)
                IDLE:    state_next_s = REQ;
                // The request issued this cycle is still owed a response.
                REQ:     state_next_s = SQUASH;
                // A response arriving with the redirect retires the request.
                WAIT: begin
                    if (ufp_resp) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = SQUASH;
                    end
                end
                SQUASH: begin
                    if (ufp_resp) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = SQUASH;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (credit_idle_s) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                REQ:     state_next_s = WAIT;
                WAIT: begin
                    if (ufp_resp) begin
                        enq_s     = 1'b1;
                        pc_next_s = pc_advance(pc_r, PC_STEP);
                        if (credit_wait_s) begin
                            state_next_s = REQ;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        state_next_s = WAIT;
                    end
                end
                SQUASH: begin
                    if (ufp_resp) begin
                        if (credit_idle_s) begin
                            state_next_s = REQ;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        state_next_s = SQUASH;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, PC and registered read-mask (high exactly during REQ).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            rmask_r <= RMASK_NONE;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            rmask_r <= (state_next_s == REQ) ? RMASK_ALL : RMASK_NONE;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Wrapping event counters: enqueues, credit stalls, redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_r <= 32'h0;
            perf_stall_r <= 32'h0;
            perf_flush_r <= 32'h0;
        end else begin
            if (enq_s) begin
                perf_fetch_r <= perf_fetch_r + 32'h1;
            end
            if ((state_r == IDLE) && !credit_idle_s) begin
                perf_stall_r <= perf_stall_r + 32'h1;
            end
            if (redirect_valid) begin
                perf_flush_r <= perf_flush_r + 32'h1;
            end
        end
    end

    assign perf_fetch = perf_fetch_r;
    assign perf_stall = perf_stall_r;
    assign perf_flush = perf_flush_r;
`else
    assign perf_fetch = 32'h0;
    assign perf_stall = 32'h0;
    assign perf_flush = 32'h0;
`endif

endmodule
